aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer, one round per clock.
- Accepts a 128-bit plaintext block via a valid/ready handshake and performs the initial AddRoundKey.
- Sequences rounds 1..NR through a shared combinational round datapath: SubBytes, shiftRow, MixColumns, AddRoundKey. MixColumns is bypassed in the final round.
- Requests round keys by index from an external key-schedule store; presents the ciphertext via valid/ready.

Parameters:
- NR, 10, number of rounds (10 for AES-128; legal values 10, 12, 14).
- RK_IDX_W, 4, width of the round-key index; must satisfy 2**RK_IDX_W > NR.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  plaintext valid.
- in_ready  output  1  controller can accept a block.
- in_data  input  128  plaintext. Byte 0 (row0,col0) is [127:120]; column-major order.
- rk_idx  output  RK_IDX_W  round-key index requested this cycle.
- rk_data  input  128  round key for rk_idx, valid combinationally in the same cycle.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts ciphertext.
- out_data  output  128  ciphertext, same byte order as in_data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, round counter=0, state register=0. Outputs: in_ready=1 after release, out_valid=0, out_data=0, busy=0, rk_idx=0.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid&in_ready: state <= in_data ^ rk_data, rnd <= 1.
  - If NR==1 go to FINAL, else go to ROUND.
- ROUND:
  - rk_idx=rnd.
  - state <= MixColumns(shiftRow(SubBytes(state))) ^ rk_data; rnd <= rnd+1.
  - When rnd==NR-1 go to FINAL.
- FINAL:
  - rk_idx=NR.
  - state <= shiftRow(SubBytes(state)) ^ rk_data.
  - Go to DONE.
- DONE:
  - out_valid=1; out_data=state, held stable until out_ready.
  - On out_ready: out_valid drops next cycle, go to IDLE.
- Latency: acceptance at cycle 0 gives out_valid at cycle NR+1 (11 for AES-128).
- Throughput: one block per NR+2 cycles at best; no overlap.
- in_ready is 0 in ROUND/FINAL/DONE. in_valid outside IDLE is ignored; in_data is not sampled.
- out_ready outside DONE is ignored. out_ready and in_valid high together in DONE: only the output completes; the new block is accepted in the following IDLE cycle.
- rk_idx is a function of FSM and rnd only, never of in_valid or out_ready.
- rnd never exceeds NR; no wrap.
- Reset asserted mid-operation: immediate return to IDLE. Partial state is discarded; no out_valid is produced.

Optional Feature:
- Macro AES_ROUND_CTRL_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in ROUND, FINAL or DONE: go to IDLE next cycle, clear state and rnd, out_valid=0. No ciphertext is emitted.
  - abort in IDLE is ignored.
  - abort has priority over out_ready in DONE.
- Not defined: port absent; behaviour exactly as above.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128.
  - Default NR per key size.
  - FSM state enum.
  - Byte-index helper constants for the column-major layout.
- Sub-module aes_round_dp (combinational):
  - Inputs state, round key, last_round flag.
  - Chains SubBytes, shiftRow, MixColumns (bypassed when last_round=1), AddRoundKey.
  - The controller instantiates one copy and owns all registers.

Test Plan:
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f (bench supplies expanded keys on rk_idx), pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after acceptance.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; rk_idx sequence 0,1,...,10, each index exactly once.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0, a second in_valid is not accepted; release -> second block accepted in the following IDLE cycle.
- Back-to-back: in_valid held high, out_ready=1 -> blocks complete every 12 cycles, both ciphertexts correct.
- Reset mid-round: drop rst_n at round 5 -> out_valid=0, busy=0, in_ready=1 after release; the next block encrypts correctly.
- ABORT_EN build: abort at round 3 -> IDLE next cycle, no out_valid; the next vector is correct.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM state type, byte layout helpers and S-box/xtime functions
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int NR_AES128   = 10;
    localparam int NR_AES192   = 12;
    localparam int NR_AES256   = 14;
    localparam int N_ROWS      = 4;
    localparam int N_COLS      = 4;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    // byte (row r, col c) sits at this LSB in a column-major block whose byte 0 is [127:120]
    function automatic int byte_lsb(input int r, input int c);
        return 120 - 8 * (r + N_ROWS * c);
    endfunction

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2040 - 8 * int'(b) +: 8];
    endfunction

    // multiply by x in GF(2^8) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: plaintext/ciphertext handshakes and round-key lookup bus
interface aes_round_ctrl_if #(
    parameter int RK_IDX_W = 4
);
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_BLOCK_W-1:0] in_data;
    logic [RK_IDX_W-1:0]    rk_idx;
    logic [AES_BLOCK_W-1:0] rk_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_BLOCK_W-1:0] out_data;

    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );

endinterface

// File: rtl/aes_round_dp.sv
// aes_round_dp: one combinational AES round (SubBytes, ShiftRows, MixColumns unless last, AddRoundKey)
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state_i,
    input  logic [AES_BLOCK_W-1:0] rk_i,
    input  logic                   last_round_i,
    output logic [AES_BLOCK_W-1:0] state_o
);

    logic [AES_BLOCK_W-1:0] sr;
    logic [AES_BLOCK_W-1:0] mc;

    // row r of column c takes the substituted byte from column c+r; each mixed byte is 2a_r+3a_{r+1}+a_{r+2}+a_{r+3}
    always_comb begin
        sr      = '0;
        mc      = '0;
        state_o = '0;
        for (int c = 0; c < N_COLS; c++)
            for (int r = 0; r < N_ROWS; r++)
                sr[byte_lsb(r, c) +: 8] = sbox(state_i[byte_lsb(r, (c + r) % N_COLS) +: 8]);
        for (int c = 0; c < N_COLS; c++)
            for (int r = 0; r < N_ROWS; r++)
                mc[byte_lsb(r, c) +: 8] = xtime(sr[byte_lsb(r, c) +: 8] ^ sr[byte_lsb((r + 1) % N_ROWS, c) +: 8])
                                        ^ sr[byte_lsb((r + 1) % N_ROWS, c) +: 8]
                                        ^ sr[byte_lsb((r + 2) % N_ROWS, c) +: 8]
                                        ^ sr[byte_lsb((r + 3) % N_ROWS, c) +: 8];
        state_o = (last_round_i ? sr : mc) ^ rk_i;
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption sequencer, one round per clock; AES_ROUND_CTRL_ABORT_EN adds an abort input
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR       = NR_AES128,
    parameter int RK_IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_round_ctrl_if.slave bus,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic            abort,
`endif
    output logic            busy
);

    state_e                 st_q, st_d;
    logic [RK_IDX_W-1:0]    rnd_q, rnd_d;
    logic [AES_BLOCK_W-1:0] blk_q, blk_d;
    logic [AES_BLOCK_W-1:0] dp_out;
    logic                   last_round;

    aes_round_dp u_dp (
        .state_i      (blk_q),
        .rk_i         (bus.rk_data),
        .last_round_i (last_round),
        .state_o      (dp_out)
    );

    // sequencing, key-index selection and block-register update
    always_comb begin
        st_d          = st_q;
        rnd_d         = rnd_q;
        blk_d         = blk_q;
        last_round    = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.rk_idx    = '0;
        case (st_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    blk_d = bus.in_data ^ bus.rk_data;
                    rnd_d = RK_IDX_W'(1);
                    st_d  = (NR == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                bus.rk_idx = rnd_q;
                blk_d      = dp_out;
                rnd_d      = rnd_q + 1'b1;
                if (rnd_q == RK_IDX_W'(NR - 1)) st_d = FINAL;
            end
            FINAL: begin
                bus.rk_idx = RK_IDX_W'(NR);
                last_round = 1'b1;
                blk_d      = dp_out;
                st_d       = DONE;
            end
            default: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) st_d = IDLE;
            end
        endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
        if (abort && st_q != IDLE) begin
            st_d  = IDLE;
            rnd_d = '0;
            blk_d = '0;
        end
`endif
    end

    // controller registers; reset discards any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            rnd_q <= '0;
            blk_q <= '0;
        end else begin
            st_q  <= st_d;
            rnd_q <= rnd_d;
            blk_q <= blk_d;
        end
    end

    assign busy         = st_q != IDLE;
    assign bus.out_data = (st_q == DONE) ? blk_q : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed FIPS-197 vectors, handshake, backpressure, reset and abort checks
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic         busy;
    logic [127:0] rk [16];
    int           errors = 0;
    int           checks = 0;
    int           rk_log[$];
    int           cyc;
    int           bad;
    int           n;

    aes_round_ctrl_if #(.RK_IDX_W(4)) bif ();

    aes_round_ctrl #(.NR(10), .RK_IDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // key-schedule store: combinational lookup of the requested round key
    always_comb bif.rk_data = rk[bif.rk_idx];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic accept(input logic [127:0] pt);
        int k;
        k = 0;
        bif.in_valid = 1'b1;
        bif.in_data  = pt;
        while (!bif.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("accept_wait", 128'(k < 50), 128'(1));
        rk_log.delete();
        rk_log.push_back(int'(bif.rk_idx));
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        c = 1;
        while (!bif.out_valid && c < 40) begin
            rk_log.push_back(int'(bif.rk_idx));
            @(negedge clk);
            c++;
        end
    endtask

    task automatic release_out();
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) rk[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy_during", 128'(busy), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(bif.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bif.out_valid), 128'(0));
        chk("rst_out_data", bif.out_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_rk_idx", 128'(bif.rk_idx), 128'(0));

        set_key(KA);
        accept(PA);
        wait_out(cyc);
        chk("c1_latency", 128'(cyc), 128'(11));
        chk("c1_data", bif.out_data, CA);
        release_out();
        chk("c1_drop", 128'(bif.out_valid), 128'(0));

        set_key(KB);
        accept(PB);
        wait_out(cyc);
        chk("b_latency", 128'(cyc), 128'(11));
        chk("b_data", bif.out_data, CB);
        chk("b_rk_count", 128'(rk_log.size()), 128'(11));
        for (int i = 0; i < rk_log.size(); i++) chk($sformatf("b_rk_idx%0d", i), 128'(rk_log[i]), 128'(i));

        set_key(KA);
        bif.in_valid = 1'b1;
        bif.in_data  = PA;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bif.out_data !== CB || bif.in_ready !== 1'b0 || bif.out_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        chk("bp_hold_bad_cycles", 128'(bad), 128'(0));
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        chk("bp_drop", 128'(bif.out_valid), 128'(0));
        chk("bp_idle_ready", 128'(bif.in_ready), 128'(1));
        @(negedge clk);
        chk("bp_accepted", 128'(busy), 128'(1));
        bif.in_valid = 1'b0;
        wait_out(cyc);
        chk("bp_latency", 128'(cyc), 128'(11));
        chk("bp_data", bif.out_data, CA);

        bif.out_ready = 1'b1;
        bif.in_valid  = 1'b1;
        bif.in_data   = PA;
        @(negedge clk);
        chk("b2b_idle0", 128'(bif.in_ready), 128'(1));
        @(negedge clk);
        wait_out(cyc);
        chk("b2b_latency0", 128'(cyc), 128'(11));
        chk("b2b_data0", bif.out_data, CA);
        set_key(KB);
        bif.in_data = PB;
        @(negedge clk);
        chk("b2b_idle1", 128'(bif.in_ready), 128'(1));
        @(negedge clk);
        bif.in_valid = 1'b0;
        cyc = 2;
        while (!bif.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_period", 128'(cyc), 128'(12));
        chk("b2b_data1", bif.out_data, CB);
        @(negedge clk);
        bif.out_ready = 1'b0;
        chk("b2b_drop", 128'(bif.out_valid), 128'(0));

        set_key(KA);
        accept(PA);
        n = 0;
        while (bif.rk_idx != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach_round5", 128'(n < 20), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 128'(busy), 128'(0));
        chk("mid_out_valid", 128'(bif.out_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_in_ready", 128'(bif.in_ready), 128'(1));
        chk("mid_busy_after", 128'(busy), 128'(0));
        set_key(KB);
        accept(PB);
        wait_out(cyc);
        chk("mid_next_latency", 128'(cyc), 128'(11));
        chk("mid_next_data", bif.out_data, CB);
        release_out();

`ifdef AES_ROUND_CTRL_ABORT_EN
        set_key(KA);
        accept(PA);
        n = 0;
        while (bif.rk_idx != 4'd3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ab_reach_round3", 128'(n < 20), 128'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", 128'(busy), 128'(0));
        chk("ab_in_ready", 128'(bif.in_ready), 128'(1));
        chk("ab_out_valid", 128'(bif.out_valid), 128'(0));
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (bif.out_valid !== 1'b0) bad++;
        end
        chk("ab_no_output", 128'(bad), 128'(0));
        set_key(KB);
        accept(PB);
        wait_out(cyc);
        chk("ab_next_latency", 128'(cyc), 128'(11));
        chk("ab_next_data", bif.out_data, CB);
        release_out();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
